// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and index-width helper for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic [0:0] {ARB_IDLE, ARB_BURST} arb_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: producer-side request bus plus FIFO write port and status
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  import fifo_arb_pkg::*;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wen;
  logic [WIDTH-1:0]              fifo_data;
  logic                          fifo_full;
  logic                          fifo_almost_full;
  logic [idx_w(NUM_REQ)-1:0]     grant_id;
  logic                          busy;
  modport master (
    output req_valid, req_data, req_last, fifo_full, fifo_almost_full,
    input  req_ready, fifo_wen, fifo_data, grant_id, busy
  );
  modport slave (
    input  req_valid, req_data, req_last, fifo_full, fifo_almost_full,
    output req_ready, fifo_wen, fifo_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick: first set bit of i_vec at or after i_start, wrapping at NUM_REQ
module rr_pick import fifo_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_vec,
  input  logic [IW-1:0]      i_start,
  output logic               o_found,
  output logic [IW-1:0]      o_idx
);
  assign o_found = |i_vec;
  // Scan farthest offset first so the nearest hit overwrites it
  always_comb begin
    o_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_vec[IW'((int'(i_start) + i) % NUM_REQ)]) o_idx = IW'((int'(i_start) + i) % NUM_REQ);
    end
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port
module fifo_write_arbiter import fifo_arb_pkg::*; #(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 8,
  parameter int MAX_BURST    = 4,
  parameter int IDLE_TIMEOUT = 8
) (
  input logic clk,
  input logic rst,
  fifo_write_arbiter_if.slave bus
);
  localparam int GW = idx_w(NUM_REQ);
  localparam int BW = idx_w(MAX_BURST + 1);
  localparam int TW = idx_w(IDLE_TIMEOUT + 1);

  arb_state_e    r_state;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_ptr;
  logic [BW-1:0] r_beat_cnt;
  logic [TW-1:0] r_idle_cnt;
  logic          w_found;
  logic [GW-1:0] w_pick;
  logic          w_busy;
  logic          w_valid;
  logic          w_beat;
  logic          w_last_beat;
  logic          w_timeout;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(GW)) u_pick (
    .i_vec   (bus.req_valid),
    .i_start (r_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_busy      = r_state == ARB_BURST;
  assign w_valid     = bus.req_valid[r_grant];
  assign w_beat      = w_busy && w_valid && !bus.fifo_full;
  assign w_last_beat = w_beat && (bus.req_last[r_grant] || r_beat_cnt == BW'(MAX_BURST - 1));
  // A full FIFO with valid held high is not idleness; only owner valid-low counts
  assign w_timeout   = (IDLE_TIMEOUT != 0) && w_busy && !w_valid && r_idle_cnt == TW'(IDLE_TIMEOUT - 1);

  assign bus.req_ready = (w_busy && !bus.fifo_full) ? NUM_REQ'(1) << r_grant : '0;
  assign bus.fifo_wen  = w_beat;
  assign bus.fifo_data = bus.req_data[r_grant];
  assign bus.grant_id  = r_grant;
  assign bus.busy      = w_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_grant    <= '0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
    end else if (!w_busy) begin
      if (w_found && !bus.fifo_almost_full) begin
        r_state    <= ARB_BURST;
        r_grant    <= w_pick;
        r_beat_cnt <= '0;
        r_idle_cnt <= '0;
      end
    end else if (w_last_beat || w_timeout) begin
      r_state <= ARB_IDLE;
      r_ptr   <= (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
    end else if (w_beat) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
      r_idle_cnt <= '0;
    end else if (!w_valid) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;

  fifo_write_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();
  fifo_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB), .IDLE_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid        = '0;
    bus.req_last         = '0;
    bus.req_data         = '0;
    bus.fifo_full        = 1'b0;
    bus.fifo_almost_full = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.req_valid = '1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", bus.grant_id); end
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
    checks++; if (bus.fifo_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0b expected 0", bus.fifo_wen); end
    next_cycle();
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [N];
    int g;
    for (int i = 0; i < N; i++) begin
      seq[i] = '0;
      bus.req_data[i] = {4'(i), 4'h0};
    end
    bus.req_last  = '0;
    bus.req_valid = '1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_start_busy: got %0b expected 0", bus.busy); end
    next_cycle();
    for (int gi = 0; gi < 5; gi++) begin
      g = gi % N;
      for (int b = 0; b < MB; b++) begin
        @(negedge clk);
        checks++; if (bus.grant_id !== 2'(g)) begin errors++; $display("FAIL rr_grant: got %0d expected %0d", bus.grant_id, g); end
        checks++; if (bus.fifo_wen !== 1'b1) begin errors++; $display("FAIL rr_wen: got %0b expected 1 (grant %0d beat %0d)", bus.fifo_wen, g, b); end
        checks++; if (bus.req_ready !== 4'(1 << g)) begin errors++; $display("FAIL rr_ready: got %b expected %b", bus.req_ready, 4'(1 << g)); end
        checks++; if (bus.fifo_data !== {4'(g), seq[g]}) begin errors++; $display("FAIL rr_data: got %h expected %h", bus.fifo_data, {4'(g), seq[g]}); end
        next_cycle();
        seq[g]++;
        bus.req_data[g] = {4'(g), seq[g]};
      end
      if (gi == 4) bus.req_valid = '0;
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0 || bus.fifo_wen !== 1'b0) begin errors++; $display("FAIL rr_bubble: got busy=%0b wen=%0b expected 0 0", bus.busy, bus.fifo_wen); end
      next_cycle();
    end
  endtask

  task automatic test_single();
    logic [7:0] beats [3];
    int k = 0, first = -1, lastc = -1, nw = 0;
    beats = '{8'hA1, 8'hA2, 8'hA3};
    clear_inputs();
    for (int c = 0; c < 6; c++) begin
      bus.req_data[2]  = (k < 3) ? beats[k] : 8'h00;
      bus.req_last[2]  = (k == 2);
      bus.req_valid[2] = (k < 3);
      @(negedge clk);
      if (c == 1) begin
        checks++; if (bus.grant_id !== 2'd2) begin errors++; $display("FAIL single_grant: got %0d expected 2", bus.grant_id); end
      end
      if (bus.fifo_wen === 1'b1) begin
        checks++;
        if (k >= 3) begin errors++; $display("FAIL single_extra_write: got %h expected none", bus.fifo_data); end
        else if (bus.fifo_data !== beats[k]) begin errors++; $display("FAIL single_data: got %h expected %h", bus.fifo_data, beats[k]); end
        if (first < 0) first = c;
        lastc = c;
        nw++;
        k++;
      end
      next_cycle();
    end
    checks++; if (first != 1) begin errors++; $display("FAIL single_first_beat: got cycle %0d expected 1", first); end
    checks++; if (nw != 3 || lastc != 3) begin errors++; $display("FAIL single_beats: got %0d ending cycle %0d expected 3 ending 3", nw, lastc); end
    bus.req_valid = 4'b1001;
    bus.req_last  = 4'b1001;
    bus.req_data[3] = 8'h3C;
    bus.req_data[0] = 8'h0C;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ptr_idle: got %0b expected 0", bus.busy); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.grant_id !== 2'd3 || bus.fifo_wen !== 1'b1) begin errors++; $display("FAIL ptr_after_single: got grant=%0d wen=%0b expected 3 1", bus.grant_id, bus.fifo_wen); end
    next_cycle();
    bus.req_valid[3] = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ptr_bubble: got %0b expected 0", bus.busy); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.grant_id !== 2'd0 || bus.fifo_data !== 8'h0C) begin errors++; $display("FAIL ptr_wrap: got grant=%0d data=%h expected 0 0c", bus.grant_id, bus.fifo_data); end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [7:0] beats [3];
    int k = 0, lastc = -1, nw = 0;
    beats = '{8'hB0, 8'hB1, 8'hB2};
    clear_inputs();
    for (int c = 0; c < 16; c++) begin
      bus.req_data[1]  = (k < 3) ? beats[k] : 8'h00;
      bus.req_last[1]  = (k == 2);
      bus.req_valid[1] = (k < 3);
      bus.fifo_full    = (c >= 2 && c < 12);
      @(negedge clk);
      if (c >= 2 && c < 12) begin
        checks++; if (bus.req_ready !== 4'b0 || bus.fifo_wen !== 1'b0) begin errors++; $display("FAIL bp_stall: got ready=%b wen=%0b expected 0000 0 (cycle %0d)", bus.req_ready, bus.fifo_wen, c); end
        checks++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'd1) begin errors++; $display("FAIL bp_hold: got busy=%0b grant=%0d expected 1 1 (cycle %0d)", bus.busy, bus.grant_id, c); end
      end
      if (bus.fifo_wen === 1'b1) begin
        checks++;
        if (k >= 3) begin errors++; $display("FAIL bp_extra_write: got %h expected none", bus.fifo_data); end
        else if (bus.fifo_data !== beats[k]) begin errors++; $display("FAIL bp_data: got %h expected %h", bus.fifo_data, beats[k]); end
        lastc = c;
        nw++;
        k++;
      end
      next_cycle();
    end
    checks++; if (nw != 3 || lastc != 13) begin errors++; $display("FAIL bp_beats: got %0d ending cycle %0d expected 3 ending 13", nw, lastc); end
    clear_inputs();
  endtask

  task automatic test_timeout();
    logic exp_busy;
    clear_inputs();
    bus.req_valid   = 4'b1100;
    bus.req_last    = 4'b1000;
    bus.req_data[2] = 8'h2A;
    bus.req_data[3] = 8'h3A;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      exp_busy = (c >= 1 && c <= 9) || c == 11;
      checks++; if (bus.busy !== exp_busy) begin errors++; $display("FAIL to_busy: got %0b expected %0b (cycle %0d)", bus.busy, exp_busy, c); end
      if (c == 1 || c == 11) begin
        checks++; if (bus.fifo_wen !== 1'b1 || bus.grant_id !== ((c == 1) ? 2'd2 : 2'd3)) begin errors++; $display("FAIL to_grant: got wen=%0b grant=%0d expected 1 %0d (cycle %0d)", bus.fifo_wen, bus.grant_id, (c == 1) ? 2 : 3, c); end
      end else begin
        checks++; if (bus.fifo_wen !== 1'b0) begin errors++; $display("FAIL to_wen: got %0b expected 0 (cycle %0d)", bus.fifo_wen, c); end
      end
      next_cycle();
      if (c == 1) bus.req_valid[2] = 1'b0;
      if (c == 11) bus.req_valid[3] = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_almost_full();
    clear_inputs();
    bus.fifo_almost_full = 1'b1;
    bus.req_valid   = 4'b0010;
    bus.req_last    = 4'b0010;
    bus.req_data[1] = 8'h1F;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 5) begin
        checks++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'd1 || bus.fifo_data !== 8'h1F || bus.fifo_wen !== 1'b1) begin errors++; $display("FAIL af_grant: got busy=%0b grant=%0d wen=%0b data=%h expected 1 1 1 1f", bus.busy, bus.grant_id, bus.fifo_wen, bus.fifo_data); end
      end else begin
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL af_block: got %0b expected 0 (cycle %0d)", bus.busy, c); end
      end
      next_cycle();
      if (c == 3) bus.fifo_almost_full = 1'b0;
      if (c == 5) bus.req_valid = '0;
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    clear_inputs();
    bus.req_valid   = 4'b0100;
    bus.req_data[2] = 8'h20;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c > 0) begin
        checks++; if (bus.fifo_wen !== 1'b1 || bus.grant_id !== 2'd2) begin errors++; $display("FAIL ar_beat: got wen=%0b grant=%0d expected 1 2", bus.fifo_wen, bus.grant_id); end
      end
      next_cycle();
      if (c > 0) bus.req_data[2] = bus.req_data[2] + 8'h01;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.fifo_wen !== 1'b0 || bus.req_ready !== 4'b0 || bus.grant_id !== 2'd0) begin errors++; $display("FAIL ar_immediate: got busy=%0b wen=%0b ready=%b grant=%0d expected 0 0 0000 0", bus.busy, bus.fifo_wen, bus.req_ready, bus.grant_id); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 4'b0111;
    bus.req_last  = 4'b0111;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ar_idle: got %0b expected 0", bus.busy); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.grant_id !== 2'd0 || bus.fifo_wen !== 1'b1) begin errors++; $display("FAIL ar_restart: got grant=%0d wen=%0b expected 0 1", bus.grant_id, bus.fifo_wen); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_random();
    int m_owner = -1, m_ptr = 0, m_beats = 0, m_idle = 0, m_gid = 0, o, j, pv = 60;
    logic [7:0] d [N];
    logic l [N];
    logic e_busy, e_wen;
    logic [3:0] e_ready;
    do_reset();
    for (int i = 0; i < N; i++) begin
      d[i] = {2'(i), 6'($urandom)};
      l[i] = ($urandom_range(3) == 0);
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 50 == 0) pv = ($urandom_range(2) == 0) ? 95 : ($urandom_range(1) == 0) ? 60 : 12;
      for (int i = 0; i < N; i++) begin
        bus.req_valid[i] = ($urandom_range(99) < pv);
        bus.req_data[i]  = d[i];
        bus.req_last[i]  = l[i];
      end
      bus.fifo_full        = ($urandom_range(4) == 0);
      bus.fifo_almost_full = ($urandom_range(4) == 0);
      o       = m_owner;
      e_busy  = (o >= 0);
      e_ready = (e_busy && !bus.fifo_full) ? 4'(1 << o) : 4'b0;
      e_wen   = e_busy && bus.req_valid[(o < 0) ? 0 : o] && !bus.fifo_full;
      @(negedge clk);
      checks++; if (bus.busy !== e_busy) begin errors++; $display("FAIL rnd_busy: got %0b expected %0b (cycle %0d)", bus.busy, e_busy, cyc); end
      checks++; if (bus.grant_id !== 2'(m_gid)) begin errors++; $display("FAIL rnd_grant: got %0d expected %0d (cycle %0d)", bus.grant_id, m_gid, cyc); end
      checks++; if (bus.req_ready !== e_ready) begin errors++; $display("FAIL rnd_ready: got %b expected %b (cycle %0d)", bus.req_ready, e_ready, cyc); end
      checks++; if (bus.fifo_wen !== e_wen) begin errors++; $display("FAIL rnd_wen: got %0b expected %0b (cycle %0d)", bus.fifo_wen, e_wen, cyc); end
      if (e_wen) begin
        checks++; if (bus.fifo_data !== d[o]) begin errors++; $display("FAIL rnd_data: got %h expected %h (cycle %0d)", bus.fifo_data, d[o], cyc); end
      end
      @(posedge clk);
      if (!e_busy) begin
        if (|bus.req_valid && !bus.fifo_almost_full) begin
          j = m_ptr;
          while (!bus.req_valid[j]) j = (j + 1) % N;
          m_owner = j;
          m_gid   = j;
          m_beats = 0;
          m_idle  = 0;
        end
      end else begin
        if (e_wen) begin
          m_beats++;
          m_idle = 0;
        end else if (!bus.req_valid[o]) begin
          m_idle++;
        end
        if ((e_wen && (l[o] || m_beats == MB)) || m_idle == TO) begin
          m_ptr   = (o + 1) % N;
          m_owner = -1;
        end
        if (e_wen) begin
          d[o] = {2'(o), 6'($urandom)};
          l[o] = ($urandom_range(3) == 0);
        end
      end
      #1;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_timeout();
    test_almost_full();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
